// File: rtl/ext_bus_master.sv
// Multiplexed address/data external bus master: AH/AHH/AL/ALH latch phases, then a DATA strobe phase.
// Optional build macro SKIP_ADDR_HI_EN: skip the high-address phases when addr[15:8] matches the last one emitted.
module ext_bus_master #(
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [7:0]  bus_out,
    input  logic [7:0]  bus_in,
    output logic        bus_dir,
    output logic        le_hi,
    output logic        le_lo,
    output logic        OEb,
    output logic        WEb
);

    typedef enum logic [2:0] {IDLE, AH, AHH, AL, ALH, DATA} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic [7:0]  bus_out_q, bus_out_d;
    logic        bus_dir_q, bus_dir_d;
    logic        le_hi_q, le_hi_d;
    logic        le_lo_q, le_lo_d;
    logic        oeb_q, oeb_d;
    logic        web_q, web_d;
    logic        accept;
    logic        final_data;
    logic        data_d;
`ifdef SKIP_ADDR_HI_EN
    logic [7:0]  hi_q, hi_d;
    logic        hi_vld_q, hi_vld_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            bus_out_q   <= '0;
            bus_dir_q   <= 1'b1;
            le_hi_q     <= 1'b0;
            le_lo_q     <= 1'b0;
            oeb_q       <= 1'b1;
            web_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            bus_out_q   <= bus_out_d;
            bus_dir_q   <= bus_dir_d;
            le_hi_q     <= le_hi_d;
            le_lo_q     <= le_lo_d;
            oeb_q       <= oeb_d;
            web_q       <= web_d;
        end
    end

`ifdef SKIP_ADDR_HI_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q     <= '0;
            hi_vld_q <= 1'b0;
        end else begin
            hi_q     <= hi_d;
            hi_vld_q <= hi_vld_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        bus_out_d   = bus_out_q;
`ifdef SKIP_ADDR_HI_EN
        hi_d        = hi_q;
        hi_vld_d    = hi_vld_q;
`endif
        // req_ready_q is only ever high in IDLE or the last DATA cycle
        accept     = req_valid && req_ready_q;
        final_data = (state_q == DATA) && (wait_q == 4'd0);

        case (state_q)
            AH:   state_d = AHH;
            AHH:  state_d = AL;
            AL:   state_d = ALH;
            ALH: begin
                state_d = DATA;
                wait_d  = 4'(WAIT_STATES);
            end
            DATA: begin
                if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
                else                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (final_data) begin
            rsp_valid_d = 1'b1;
            if (!we_q) rsp_rdata_d = bus_in;
        end

        if (accept) begin
            we_d    = req_we;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            state_d = AH;
`ifdef SKIP_ADDR_HI_EN
            if (hi_vld_q && (req_addr[15:8] == hi_q)) begin
                state_d = AL;
            end else begin
                hi_d     = req_addr[15:8];
                hi_vld_d = 1'b1;
            end
`endif
        end

        // outputs are registered, so they are decoded from the state being entered
        data_d    = (state_d == DATA);
        le_hi_d   = (state_d == AH);
        le_lo_d   = (state_d == AL);
        oeb_d     = !(data_d && !we_d);
        web_d     = !(data_d && we_d);
        bus_dir_d = !((state_d inside {AH, AHH, AL, ALH}) || (data_d && we_d));
        case (state_d)
            AH:      bus_out_d = addr_d[15:8];
            AL:      bus_out_d = addr_d[7:0];
            DATA:    if (we_d) bus_out_d = wdata_d;
            default: ;
        endcase
        req_ready_d = (state_d == IDLE) || (data_d && (wait_d == 4'd0));
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign bus_out   = bus_out_q;
    assign bus_dir   = bus_dir_q;
    assign le_hi     = le_hi_q;
    assign le_lo     = le_lo_q;
    assign OEb       = oeb_q;
    assign WEb       = web_q;

endmodule
